// File: rtl/mwadd_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
// Optional overflow output is enabled by defining MWADD_OVF_EN.
package mwadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Slice counter width; a single-word build still needs one bit.
    function automatic int cntWidth(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/mwadd_sequencer_if.sv
// Operand/result handshakes plus the narrow adder port bundle of mwadd_sequencer.
// oOvf exists only when MWADD_OVF_EN is defined.
interface mwadd_sequencer_if
    import mwadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
);
    // Both handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and the payload is stable while
    // valid waits for ready.
    logic                     iValid;
    logic                     oReady;
    logic [WIDTH*WORDS-1:0]   iA;
    logic [WIDTH*WORDS-1:0]   iB;
    logic                     iC;
    logic                     oValid;
    logic                     iReady;
    logic [WIDTH*WORDS-1:0]   oS;
    logic                     oC;
    logic [WIDTH-1:0]         oAddA;
    logic [WIDTH-1:0]         oAddB;
    logic                     oAddC;
    logic [WIDTH-1:0]         iAddS;
    logic                     iAddC;
    stateT                    oState;
`ifdef MWADD_OVF_EN
    logic                     oOvf;
`endif

    modport slave (
        input  iValid, iA, iB, iC, iReady, iAddS, iAddC,
        output oReady, oValid, oS, oC, oAddA, oAddB, oAddC, oState
`ifdef MWADD_OVF_EN
        , output oOvf
`endif
    );

    modport master (
        output iValid, iA, iB, iC, iReady, iAddS, iAddC,
        input  oReady, oValid, oS, oC, oAddA, oAddB, oAddC, oState
`ifdef MWADD_OVF_EN
        , input oOvf
`endif
    );

endinterface

// File: rtl/mwadd_sequencer.sv
// Runs a WORDS x WIDTH-bit addition through one external WIDTH-bit adder, LSW first.
// Define MWADD_OVF_EN to add the registered two's-complement overflow output oOvf.
module mwadd_sequencer
    import mwadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic               iClk,
    input  logic               iRstN,
    mwadd_sequencer_if.slave   bus
);
    localparam int            TOT  = WIDTH * WORDS;
    localparam int            CW   = cntWidth(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    stateT             state;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic [TOT-1:0]    opA;
    logic [TOT-1:0]    opB;
    logic [TOT-1:0]    res;
    logic [WIDTH-1:0]  addA;
    logic [WIDTH-1:0]  addB;
    logic              addC;
    logic              readyR;
    logic              validR;
`ifdef MWADD_OVF_EN
    logic              ovfR;
`endif

    // opA/opB hold the not-yet-presented words, so the next slice is always the
    // low word and the adder ports are loaded straight from registers.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            opA    <= '0;
            opB    <= '0;
            res    <= '0;
            addA   <= '0;
            addB   <= '0;
            addC   <= 1'b0;
            readyR <= 1'b1;
            validR <= 1'b0;
`ifdef MWADD_OVF_EN
            ovfR   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iValid) begin
                        opA    <= bus.iA >> WIDTH;
                        opB    <= bus.iB >> WIDTH;
                        addA   <= bus.iA[WIDTH-1:0];
                        addB   <= bus.iB[WIDTH-1:0];
                        addC   <= bus.iC;
                        carry  <= bus.iC;
                        cnt    <= '0;
                        readyR <= 1'b0;
                        state  <= RUN;
`ifdef MWADD_OVF_EN
                        ovfR   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    res[cnt*WIDTH +: WIDTH] <= bus.iAddS;
                    carry <= bus.iAddC;
                    opA   <= opA >> WIDTH;
                    opB   <= opB >> WIDTH;
                    if (cnt == LAST) begin
                        addA   <= '0;
                        addB   <= '0;
                        addC   <= 1'b0;
                        validR <= 1'b1;
                        state  <= DONE;
`ifdef MWADD_OVF_EN
                        ovfR   <= (addA[WIDTH-1] == addB[WIDTH-1]) &&
                                  (bus.iAddS[WIDTH-1] != addA[WIDTH-1]);
`endif
                    end else begin
                        addA <= opA[WIDTH-1:0];
                        addB <= opB[WIDTH-1:0];
                        addC <= bus.iAddC;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.iReady) begin
                        validR <= 1'b0;
                        readyR <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    validR <= 1'b0;
                    readyR <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.oReady = readyR;
    assign bus.oValid = validR;
    assign bus.oS     = res;
    assign bus.oC     = carry;
    assign bus.oAddA  = addA;
    assign bus.oAddB  = addB;
    assign bus.oAddC  = addC;
    assign bus.oState = state;
`ifdef MWADD_OVF_EN
    assign bus.oOvf   = ovfR;
`endif

endmodule

// File: tb/tb_mwadd_sequencer.sv
// Directed bench for mwadd_sequencer with a combinational 16-bit adder model.
// Overflow checks are included when MWADD_OVF_EN is defined.
module tb_mwadd_sequencer;
    import mwadd_pkg::*;

    localparam int WIDTH = 16;
    localparam int WORDS = 4;
    localparam int TOT   = WIDTH * WORDS;

    typedef logic [TOT:0] valT;

    logic iClk = 1'b0;
    logic iRstN;

    always #5 iClk = ~iClk;

    mwadd_sequencer_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    mwadd_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    // The narrow adder that sits beside the sequencer in the parent.
    assign {bus.iAddC, bus.iAddS} = {1'b0, bus.oAddA} + {1'b0, bus.oAddB} +
                                    {{WIDTH{1'b0}}, bus.oAddC};

    int               nChecks = 0;
    int               nFails  = 0;
    valT              expQ[$];
    logic [TOT-1:0]   vecA[3];
    logic [TOT-1:0]   vecB[3];
    logic             vecC[3];
    valT              vecE[3];
    logic [WIDTH-1:0] addSeq[WORDS];

    task automatic checkVal(input string tag, input valT obs, input valT exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Offers one operand pair and returns one cycle after the accepting edge.
    task automatic sendOp(input int idx, input bit track);
        int k;
        bus.iA     = vecA[idx];
        bus.iB     = vecB[idx];
        bus.iC     = vecC[idx];
        bus.iValid = 1'b1;
        k = 0;
        while (!bus.oReady && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) checkVal("accept_timeout", valT'(bus.oReady), valT'(1));
        if (track) expQ.push_back(vecE[idx]);
        step();
        bus.iValid = 1'b0;
    endtask

    // Counts cycles from the accept until oValid, recording each RUN slice.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!bus.oValid && lat < 20) begin
            if (bus.oState == RUN && lat <= WORDS) addSeq[lat-1] = bus.oAddA;
            step();
            lat++;
        end
    endtask

    task automatic checkResult(input string tag);
        valT exp;
        if (expQ.size() == 0) begin
            checkVal({tag, "_unexpected"}, valT'(bus.oValid), valT'(0));
        end else begin
            exp = expQ.pop_front();
            checkVal({tag, "_sum"}, valT'(bus.oS), valT'(exp[TOT-1:0]));
            checkVal({tag, "_cout"}, valT'(bus.oC), valT'(exp[TOT]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int got;
        int idx;
        int cyc;
        int accCycle[3];
        bit acc;

        vecA[0] = 64'h0000_0000_0000_0001; vecB[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        vecC[0] = 1'b0; vecE[0] = {1'b1, 64'h0000_0000_0000_0000};
        vecA[1] = 64'h1234_5678_9ABC_DEF0; vecB[1] = 64'h1111_1111_1111_1111;
        vecC[1] = 1'b1; vecE[1] = {1'b0, 64'h2345_6789_ABCD_F002};
        vecA[2] = 64'h7FFF_FFFF_FFFF_FFFF; vecB[2] = 64'h0000_0000_0000_0001;
        vecC[2] = 1'b0; vecE[2] = {1'b0, 64'h8000_0000_0000_0000};

        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        bus.iA     = '0;
        bus.iB     = '0;
        bus.iC     = 1'b0;
        iRstN      = 1'b0;
        repeat (2) step();
        iRstN = 1'b1;

        checkVal("rst_ready", valT'(bus.oReady), valT'(1));
        checkVal("rst_valid", valT'(bus.oValid), valT'(0));
        checkVal("rst_sum",   valT'(bus.oS),     valT'(0));
        checkVal("rst_cout",  valT'(bus.oC),     valT'(0));
        checkVal("rst_adda",  valT'(bus.oAddA),  valT'(0));
        checkVal("rst_addb",  valT'(bus.oAddB),  valT'(0));
        checkVal("rst_addc",  valT'(bus.oAddC),  valT'(0));
        checkVal("rst_state", valT'(bus.oState), valT'(IDLE));

        // Carry ripples through every slice into the wide carry-out.
        sendOp(0, 1'b1);
        waitResult(lat);
        checkVal("t1_latency", valT'(lat), valT'(5));
        checkResult("t1");
`ifdef MWADD_OVF_EN
        checkVal("t1_ovf", valT'(bus.oOvf), valT'(0));
`endif
        step();
        checkVal("t1_idle", valT'(bus.oState), valT'(IDLE));
        checkVal("t1_ready", valT'(bus.oReady), valT'(1));

        // Slice order and carry-in.
        sendOp(1, 1'b1);
        waitResult(lat);
        checkVal("t2_latency", valT'(lat), valT'(5));
        checkVal("t2_adda0", valT'(addSeq[0]), valT'(16'hDEF0));
        checkVal("t2_adda1", valT'(addSeq[1]), valT'(16'h9ABC));
        checkVal("t2_adda2", valT'(addSeq[2]), valT'(16'h5678));
        checkVal("t2_adda3", valT'(addSeq[3]), valT'(16'h1234));
        checkResult("t2");
        checkVal("t2_addc_idle", valT'(bus.oAddC), valT'(0));
        step();

        // Backpressure with new operands offered while busy.
        bus.iReady = 1'b0;
        sendOp(1, 1'b1);
        waitResult(lat);
        checkVal("bp_valid", valT'(bus.oValid), valT'(1));
        bus.iA     = vecA[2];
        bus.iB     = vecB[2];
        bus.iC     = 1'b1;
        bus.iValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("bp_hold_valid", valT'(bus.oValid), valT'(1));
            checkVal("bp_hold_ready", valT'(bus.oReady), valT'(0));
            checkVal("bp_hold_sum",   valT'(bus.oS),     valT'(vecE[1][TOT-1:0]));
            checkVal("bp_hold_cout",  valT'(bus.oC),     valT'(0));
        end
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        checkResult("bp");
        step();
        checkVal("bp_idle",      valT'(bus.oState), valT'(IDLE));
        checkVal("bp_valid_low", valT'(bus.oValid), valT'(0));
        checkVal("bp_nolatch",   valT'(bus.oS),     valT'(vecE[1][TOT-1:0]));

        // Reset in the middle of a RUN discards the transaction.
        sendOp(0, 1'b0);
        step();
        checkVal("mr_running", valT'(bus.oState), valT'(RUN));
        iRstN = 1'b0;
        step();
        iRstN = 1'b1;
        checkVal("mr_state", valT'(bus.oState), valT'(IDLE));
        checkVal("mr_valid", valT'(bus.oValid), valT'(0));
        checkVal("mr_sum",   valT'(bus.oS),     valT'(0));
        checkVal("mr_cout",  valT'(bus.oC),     valT'(0));
        checkVal("mr_ready", valT'(bus.oReady), valT'(1));
        checkVal("mr_adda",  valT'(bus.oAddA),  valT'(0));
        sendOp(1, 1'b1);
        waitResult(lat);
        checkVal("mr_latency", valT'(lat), valT'(5));
        checkResult("mr_after");
        step();

        // Signed overflow into the top bit.
        sendOp(2, 1'b1);
        waitResult(lat);
        checkResult("ovf");
`ifdef MWADD_OVF_EN
        checkVal("ovf_flag", valT'(bus.oOvf), valT'(1));
`endif
        step();

        // Back-to-back with iValid held high.
        idx = 0;
        got = 0;
        cyc = 0;
        bus.iA     = vecA[0];
        bus.iB     = vecB[0];
        bus.iC     = vecC[0];
        bus.iValid = 1'b1;
        while (got < 3 && cyc < 100) begin
            if (bus.oValid) begin
                checkResult("b2b");
                got++;
            end
            acc = bus.iValid && bus.oReady;
            if (acc) begin
                accCycle[idx] = cyc;
                expQ.push_back(vecE[idx]);
                idx++;
            end
            step();
            cyc++;
            if (acc) begin
                if (idx < 3) begin
                    bus.iA = vecA[idx];
                    bus.iB = vecB[idx];
                    bus.iC = vecC[idx];
                end else begin
                    bus.iValid = 1'b0;
                end
            end
        end
        checkVal("b2b_count",   valT'(got), valT'(3));
        checkVal("b2b_space01", valT'(accCycle[1] - accCycle[0]), valT'(6));
        checkVal("b2b_space12", valT'(accCycle[2] - accCycle[1]), valT'(6));
        checkVal("b2b_drained", valT'(expQ.size()), valT'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
